// File: rtl/framebuffer_mem_controller.sv
// Downscaled RGB565 frame store: byte-addressed reads for the SPI display controller,
// valid/ready pixel writes and a whole-frame fill engine sharing one RAM port.
module framebuffer_mem_controller #(
    parameter int DISPLAY_X       = 320,
    parameter int DISPLAY_Y       = 240,
    parameter int DOWNSCALE_SHIFT = 2,
    parameter int PIX_ADDR_W      = 13
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  mem_req,
    input  logic [31:0]           mem_addr,
    output logic [7:0]            mem_out,
    output logic                  mem_ready,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [PIX_ADDR_W-1:0] wr_addr,
    input  logic [15:0]           wr_data,
    input  logic                  fill_start,
    input  logic [15:0]           fill_color,
    output logic                  fill_busy
);

    localparam int NUM_PIXELS = (DISPLAY_X >> DOWNSCALE_SHIFT) * (DISPLAY_Y >> DOWNSCALE_SHIFT);
    localparam logic [PIX_ADDR_W:0]   NUM_PIX_EXT = (PIX_ADDR_W+1)'(NUM_PIXELS);
    localparam logic [PIX_ADDR_W-1:0] LAST_PIX    = PIX_ADDR_W'(NUM_PIXELS - 1);

    typedef enum logic [1:0] {IDLE, RD_WAIT, RESP} rd_state_t;

    rd_state_t             rd_state;
    logic [15:0]           ram [NUM_PIXELS];
    logic [15:0]           rd_word_p1;
    logic                  rd_byte_p1;
    logic                  rd_inrange_p1;
    logic [PIX_ADDR_W-1:0] fill_cnt;
    logic [15:0]           fill_color_q;

    logic                  rd_issue;
    logic                  rd_inrange;
    logic [PIX_ADDR_W-1:0] rd_idx;
    logic                  fill_wr;
    logic                  ext_wr;
    logic                  ram_we;
    logic [PIX_ADDR_W-1:0] ram_wa;
    logic [15:0]           ram_wd;

    // Single RAM port: a read issue blocks both writers, the fill blocks the external port.
    assign rd_issue   = mem_req && (rd_state == IDLE);
    assign rd_inrange = mem_addr < 32'(2 * NUM_PIXELS);
    assign rd_idx     = rd_inrange ? mem_addr[PIX_ADDR_W:1] : '0;
    assign wr_ready   = !reset && !fill_busy && !rd_issue;
    assign fill_wr    = fill_busy && !rd_issue;
    assign ext_wr     = wr_valid && wr_ready && ({1'b0, wr_addr} < NUM_PIX_EXT);
    assign ram_we     = fill_wr || ext_wr;
    assign ram_wa     = fill_wr ? fill_cnt : wr_addr;
    assign ram_wd     = fill_wr ? fill_color_q : wr_data;

    // Stage p0 -> p1: RAM access, contents survive reset
    always_ff @(posedge clk) begin
        if (ram_we)
            ram[ram_wa] <= ram_wd;
        if (rd_issue)
            rd_word_p1 <= ram[rd_idx];
        if (fill_start && !fill_busy)
            fill_color_q <= fill_color;
    end

    // Stage p1 -> p2: read response and fill sequencing
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_state      <= IDLE;
            rd_byte_p1    <= 1'b0;
            rd_inrange_p1 <= 1'b0;
            mem_out       <= 8'h00;
            mem_ready     <= 1'b0;
            fill_busy     <= 1'b0;
            fill_cnt      <= '0;
        end else begin
            mem_ready <= 1'b0;
            case (rd_state)
                IDLE: begin
                    if (mem_req) begin
                        rd_byte_p1    <= mem_addr[0];
                        rd_inrange_p1 <= rd_inrange;
                        rd_state      <= RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    mem_ready <= 1'b1;
                    if (!rd_inrange_p1)
                        mem_out <= 8'h00;
                    else if (rd_byte_p1)
                        mem_out <= rd_word_p1[7:0];
                    else
                        mem_out <= rd_word_p1[15:8];
                    rd_state <= RESP;
                end
                RESP:    rd_state <= IDLE;
                default: rd_state <= IDLE;
            endcase

            if (fill_busy) begin
                if (!rd_issue) begin
                    fill_cnt <= fill_cnt + 1'b1;
                    if (fill_cnt == LAST_PIX)
                        fill_busy <= 1'b0;
                end
            end else if (fill_start) begin
                fill_cnt  <= '0;
                fill_busy <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_framebuffer_mem_controller.sv
// Bench for framebuffer_mem_controller: vector table, directed corner sequences and
// randomized traffic against a cycle-level reference model.
module tb_framebuffer_mem_controller;

    localparam int NUM = 4800;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [7:0]  mem_out;
    logic        mem_ready;
    logic        wr_valid;
    logic        wr_ready;
    logic [12:0] wr_addr;
    logic [15:0] wr_data;
    logic        fill_start;
    logic [15:0] fill_color;
    logic        fill_busy;

    always #5 clk = ~clk;

    framebuffer_mem_controller dut (
        .clk(clk), .reset(reset),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_out(mem_out), .mem_ready(mem_ready),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
        .fill_start(fill_start), .fill_color(fill_color), .fill_busy(fill_busy)
    );

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model state
    int          cyc        = 0;
    int          last_issue = -100;
    logic [7:0]  exp_rsp    = 8'h00;
    bit          rsp_known  = 1'b1;
    logic [7:0]  last_out   = 8'h00;
    bit          out_known  = 1'b1;
    logic [15:0] mdl_mem   [NUM];
    bit          mdl_known [NUM];
    bit          mdl_busy   = 1'b0;
    int          mdl_idx    = 0;
    logic [15:0] mdl_col    = 16'h0000;

    typedef struct {
        logic [12:0] waddr;
        logic [15:0] wdata;
        logic [31:0] raddr;
        logic [7:0]  exp;
    } vec_t;
    vec_t vecs [9];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // One clock cycle: predict from the current inputs, advance, compare outputs.
    task automatic tick();
        bit rd_iss;
        bit exp_wr_rdy;
        bit prev_busy;
        int pix;
        #1;
        rd_iss     = mem_req && (cyc >= last_issue + 3);
        prev_busy  = mdl_busy;
        exp_wr_rdy = !prev_busy && !rd_iss;
        chk("wr_ready", 32'(wr_ready), 32'(exp_wr_rdy));
        if (rd_iss) begin
            last_issue = cyc;
            if (mem_addr >= 32'(2 * NUM)) begin
                exp_rsp   = 8'h00;
                rsp_known = 1'b1;
            end else begin
                pix       = int'(mem_addr >> 1);
                rsp_known = mdl_known[pix];
                exp_rsp   = mem_addr[0] ? mdl_mem[pix][7:0] : mdl_mem[pix][15:8];
            end
        end
        if (prev_busy) begin
            if (!rd_iss) begin
                mdl_mem[mdl_idx]   = mdl_col;
                mdl_known[mdl_idx] = 1'b1;
                mdl_idx++;
                if (mdl_idx == NUM) mdl_busy = 1'b0;
            end
        end else if (fill_start) begin
            mdl_busy = 1'b1;
            mdl_idx  = 0;
            mdl_col  = fill_color;
        end
        if (exp_wr_rdy && wr_valid && int'(wr_addr) < NUM) begin
            mdl_mem[int'(wr_addr)]   = wr_data;
            mdl_known[int'(wr_addr)] = 1'b1;
        end
        @(posedge clk);
        #1;
        cyc++;
        chk("mem_ready", 32'(mem_ready), 32'(cyc == last_issue + 2));
        if (cyc == last_issue + 2) begin
            last_out  = exp_rsp;
            out_known = rsp_known;
        end
        if (out_known) chk("mem_out", 32'(mem_out), 32'(last_out));
        chk("fill_busy", 32'(fill_busy), 32'(mdl_busy));
    endtask

    task automatic do_reset(input int cycles);
        reset = 1'b1;
        #1;
        chk("rst_mem_ready", 32'(mem_ready), 32'(0));
        chk("rst_fill_busy", 32'(fill_busy), 32'(0));
        chk("rst_wr_ready", 32'(wr_ready), 32'(0));
        chk("rst_mem_out", 32'(mem_out), 32'(0));
        mdl_busy   = 1'b0;
        mdl_idx    = 0;
        last_issue = -100;
        last_out   = 8'h00;
        out_known  = 1'b1;
        repeat (cycles) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        reset = 1'b0;
    endtask

    task automatic do_read(input logic [31:0] a, output logic [7:0] d);
        mem_req  = 1'b1;
        mem_addr = a;
        tick();
        mem_req = 1'b0;
        tick();
        d = mem_out;
        tick();
    endtask

    task automatic do_write(input logic [12:0] a, input logic [15:0] d);
        wr_valid = 1'b1;
        wr_addr  = a;
        wr_data  = d;
        tick();
        wr_valid = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] rd;
        int busy_cnt;
        int wr_hi;
        int guard;
        int rdy;

        vecs[0] = '{13'd5,    16'hF800, 32'd10,   8'hF8};
        vecs[1] = '{13'd5,    16'hF800, 32'd11,   8'h00};
        vecs[2] = '{13'd100,  16'h1234, 32'd200,  8'h12};
        vecs[3] = '{13'd101,  16'h9876, 32'd203,  8'h76};
        vecs[4] = '{13'd4799, 16'hABCD, 32'd9598, 8'hAB};
        vecs[5] = '{13'd4799, 16'hABCD, 32'd9599, 8'hCD};
        vecs[6] = '{13'd0,    16'hBEEF, 32'd0,    8'hBE};
        vecs[7] = '{13'd4800, 16'h5555, 32'd1,    8'hEF};
        vecs[8] = '{13'd4800, 16'h5555, 32'd9600, 8'h00};

        for (int i = 0; i < NUM; i++) mdl_known[i] = 1'b0;
        reset = 1'b0; mem_req = 1'b0; mem_addr = '0; wr_valid = 1'b0; wr_addr = '0;
        wr_data = '0; fill_start = 1'b0; fill_color = '0;
        #2;
        do_reset(2);

        // Write-then-read vectors, including out-of-range read and discarded write
        for (int i = 0; i < 9; i++) begin
            do_write(vecs[i].waddr, vecs[i].wdata);
            do_read(vecs[i].raddr, rd);
            chk($sformatf("vec%0d", i), 32'(rd), 32'(vecs[i].exp));
        end

        // Read and write requested together; second read request while busy
        mem_req = 1'b1; mem_addr = 32'd20;
        wr_valid = 1'b1; wr_addr = 13'd50; wr_data = 16'hA5C3;
        #1;
        chk("t4_wr_blocked", 32'(wr_ready), 32'(0));
        tick();
        #1;
        chk("t4_wr_next", 32'(wr_ready), 32'(1));
        rdy = 0;
        tick();
        rdy += int'(mem_ready);
        mem_req = 1'b0; wr_valid = 1'b0;
        repeat (4) begin
            tick();
            rdy += int'(mem_ready);
        end
        chk("t4_one_ready", 32'(rdy), 32'(1));
        do_read(32'd100, rd);
        chk("t4_wr_landed", 32'(rd), 32'hA5);

        // Fill with no reads
        fill_start = 1'b1; fill_color = 16'h07E0;
        tick();
        fill_start = 1'b0;
        busy_cnt = 0; guard = 0;
        while (fill_busy && guard < 6000) begin
            busy_cnt++; guard++;
            tick();
        end
        chk("t2_fill_len", 32'(busy_cnt), 32'(4800));
        do_read(32'd0, rd);    chk("t2_rd0", 32'(rd), 32'h07);
        do_read(32'd9598, rd); chk("t2_rd9598", 32'(rd), 32'h07);
        do_read(32'd9599, rd); chk("t2_rd9599", 32'(rd), 32'hE0);

        // Fill interrupted by three reads
        fill_start = 1'b1; fill_color = 16'h001F;
        tick();
        fill_start = 1'b0;
        busy_cnt = 0; wr_hi = 0; guard = 0;
        while (fill_busy && guard < 6000) begin
            busy_cnt++; guard++;
            if (wr_ready) wr_hi++;
            mem_req  = (busy_cnt == 5 || busy_cnt == 15 || busy_cnt == 25);
            mem_addr = 32'(busy_cnt * 2 + 1);
            tick();
        end
        mem_req = 1'b0;
        chk("t3_fill_len", 32'(busy_cnt), 32'(4803));
        chk("t3_wr_ready_lo", 32'(wr_hi), 32'(0));

        // Reset one cycle after a read request
        mem_req = 1'b1; mem_addr = 32'd10;
        tick();
        mem_req = 1'b0;
        do_reset(2);
        rdy = 0;
        repeat (4) begin
            tick();
            rdy += int'(mem_ready);
        end
        chk("t6_no_ready", 32'(rdy), 32'(0));

        // Reset in the middle of a fill
        fill_start = 1'b1; fill_color = 16'hF00F;
        tick();
        fill_start = 1'b0;
        repeat (100) tick();
        do_reset(1);
        tick();
        do_read(32'd100, rd);  chk("t6_kept_fill", 32'(rd), 32'hF0);
        do_read(32'd8001, rd); chk("t6_old_pixel", 32'(rd), 32'h1F);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            mem_req    = ($urandom_range(0, 3) == 0);
            mem_addr   = 32'($urandom_range(0, 9700));
            wr_valid   = $urandom_range(0, 1) == 1;
            wr_addr    = 13'($urandom_range(0, 4900));
            wr_data    = 16'($urandom);
            fill_start = ($urandom_range(0, 999) == 0);
            fill_color = 16'($urandom);
            tick();
        end
        mem_req = 1'b0; wr_valid = 1'b0; fill_start = 1'b0;
        guard = 0;
        while (fill_busy && guard < 6000) begin
            guard++;
            tick();
        end
        tick();
        chk("rand_drain", 32'(fill_busy), 32'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
